ddr3_ui_arbiter: RTL and testbench

- Round-robin scheduler that shares one `ddr3_ui` transfer engine between `NUM_REQ` requesters, such as Wishbone-slave and PCIe-DMA buffer movers.
- Each requester posts a write job (ibuf→DDR3) or a read job (DDR3→obuf).
- The arbiter grants one job at a time, drives the engine's `go` and setup ports, and tracks `bsy`/`fault`.
- It returns a one-cycle done or fault pulse to the owning requester.

---
 rtl/ddr3_ui_pkg.sv | 25 ++
 rtl/ddr3_ui_arbiter_rr_pick.sv | 33 +++
 rtl/ddr3_ui_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_ddr3_ui_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_ui_pkg.sv
`default_nettype none
// ==================================================================
// ddr3_ui_pkg : shared types and constants for the ddr3_ui arbiter
// Rev 1.0
// ==================================================================
package ddr3_ui_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic DIR_WR         = 1'b1;
  localparam logic DIR_RD         = 1'b0;
  localparam int   GO_TIMEOUT_DEF = 16;

  // Index width that stays at least one bit wide.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_ui_arbiter_rr_pick.sv
`default_nettype none
// ==================================================================
// rr_pick : combinational round-robin selector, searches from last+1
// Rev 1.0
// ==================================================================
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_valid,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    o_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int c = 0; c < NUM_REQ; c++) begin
        if (!o_valid && i_req[c] && (((int'(i_last) + off) % NUM_REQ) == c)) begin
          o_valid    = 1'b1;
          o_grant[c] = 1'b1;
          o_idx      = IDX_W'(c);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ddr3_ui_arbiter.sv
`default_nettype none
// ==================================================================
// ddr3_ui_arbiter : round-robin job scheduler sharing one ddr3_ui engine
// Rev 1.0
// ==================================================================
module ddr3_ui_arbiter
  import ddr3_ui_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int BUF_DEPTH      = 10,
  parameter int MEM_ADDR_DEPTH = 28,
  parameter int GO_TIMEOUT     = GO_TIMEOUT_DEF
) (
  input  logic                          ui_clk,
  input  logic                          rst_n,
  input  logic                          i_app_phy_init_done,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_req_wr,
  input  logic [NUM_REQ*BUF_DEPTH-1:0]  i_req_count,
  input  logic [NUM_REQ*BUF_DEPTH-1:0]  i_req_buf_addr,
  input  logic [NUM_REQ*MEM_ADDR_DEPTH-1:0] i_req_ddr3_addr,
  output logic [NUM_REQ-1:0]            o_grant,
  output logic [NUM_REQ-1:0]            o_done,
  output logic [NUM_REQ-1:0]            o_fault,
  output logic                          o_ibuf_go,
  output logic                          o_obuf_go,
  output logic [BUF_DEPTH-1:0]          o_ibuf_count,
  output logic [BUF_DEPTH-1:0]          o_obuf_count,
  output logic [BUF_DEPTH-1:0]          o_ibuf_start_addrb,
  output logic [BUF_DEPTH-1:0]          o_obuf_start_addra,
  output logic [MEM_ADDR_DEPTH-1:0]     o_ibuf_ddr3_addrb,
  output logic [MEM_ADDR_DEPTH-1:0]     o_obuf_ddr3_addra,
  input  logic                          i_ibuf_bsy,
  input  logic                          i_obuf_bsy,
  input  logic                          i_ibuf_ddr3_fault,
  input  logic                          i_obuf_ddr3_fault,
  output logic                          o_busy
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int TMO_W = $clog2(GO_TIMEOUT + 1);

  arb_state_t                r_state,   w_state_nxt;
  logic [IDX_W-1:0]          r_last,    w_last_nxt;
  logic [NUM_REQ-1:0]        r_grant,   w_grant_nxt;
  logic [NUM_REQ-1:0]        r_done,    w_done_nxt;
  logic [NUM_REQ-1:0]        r_fault,   w_fault_nxt;
  logic                      r_ibuf_go, w_ibuf_go_nxt;
  logic                      r_obuf_go, w_obuf_go_nxt;
  logic                      r_dir,     w_dir_nxt;
  logic [TMO_W-1:0]          r_tmo,     w_tmo_nxt;
  logic [BUF_DEPTH-1:0]      r_ibuf_cnt,  w_ibuf_cnt_nxt;
  logic [BUF_DEPTH-1:0]      r_obuf_cnt,  w_obuf_cnt_nxt;
  logic [BUF_DEPTH-1:0]      r_ibuf_badr, w_ibuf_badr_nxt;
  logic [BUF_DEPTH-1:0]      r_obuf_badr, w_obuf_badr_nxt;
  logic [MEM_ADDR_DEPTH-1:0] r_ibuf_dadr, w_ibuf_dadr_nxt;
  logic [MEM_ADDR_DEPTH-1:0] r_obuf_dadr, w_obuf_dadr_nxt;

  logic                      w_pick_valid;
  logic [NUM_REQ-1:0]        w_pick_grant;
  logic [IDX_W-1:0]          w_pick_idx;
  logic                      w_sel_wr;
  logic [BUF_DEPTH-1:0]      w_sel_cnt;
  logic [BUF_DEPTH-1:0]      w_sel_badr;
  logic [MEM_ADDR_DEPTH-1:0] w_sel_dadr;
  logic                      w_sel_bsy;
  logic                      w_sel_fault;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .i_req   (i_req),
    .i_last  (r_last),
    .o_valid (w_pick_valid),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  // Job fields of the requester the picker is pointing at.
  always_comb begin
    w_sel_wr   = 1'b0;
    w_sel_cnt  = '0;
    w_sel_badr = '0;
    w_sel_dadr = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_pick_grant[k]) begin
        w_sel_wr   = i_req_wr[k];
        w_sel_cnt  = i_req_count[k*BUF_DEPTH +: BUF_DEPTH];
        w_sel_badr = i_req_buf_addr[k*BUF_DEPTH +: BUF_DEPTH];
        w_sel_dadr = i_req_ddr3_addr[k*MEM_ADDR_DEPTH +: MEM_ADDR_DEPTH];
      end
    end
  end

  assign w_sel_bsy   = (r_dir == DIR_WR) ? i_ibuf_bsy        : i_obuf_bsy;
  assign w_sel_fault = (r_dir == DIR_WR) ? i_ibuf_ddr3_fault : i_obuf_ddr3_fault;

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_grant_nxt     = r_grant;
    w_done_nxt      = '0;
    w_fault_nxt     = '0;
    w_ibuf_go_nxt   = r_ibuf_go;
    w_obuf_go_nxt   = r_obuf_go;
    w_dir_nxt       = r_dir;
    w_tmo_nxt       = r_tmo;
    w_ibuf_cnt_nxt  = r_ibuf_cnt;
    w_obuf_cnt_nxt  = r_obuf_cnt;
    w_ibuf_badr_nxt = r_ibuf_badr;
    w_obuf_badr_nxt = r_obuf_badr;
    w_ibuf_dadr_nxt = r_ibuf_dadr;
    w_obuf_dadr_nxt = r_obuf_dadr;
    case (r_state)
      ST_IDLE: begin
        if (i_app_phy_init_done && w_pick_valid) begin
          w_last_nxt  = w_pick_idx;
          w_grant_nxt = w_pick_grant;
          w_dir_nxt   = w_sel_wr;
          w_tmo_nxt   = '0;
          if (w_sel_wr == DIR_WR) begin
            w_ibuf_cnt_nxt  = w_sel_cnt;
            w_ibuf_badr_nxt = w_sel_badr;
            w_ibuf_dadr_nxt = w_sel_dadr;
          end else begin
            w_obuf_cnt_nxt  = w_sel_cnt;
            w_obuf_badr_nxt = w_sel_badr;
            w_obuf_dadr_nxt = w_sel_dadr;
          end
          // Empty jobs complete without touching the engine.
          if (w_sel_cnt == '0) begin
            w_state_nxt = ST_RESP;
            w_done_nxt  = w_pick_grant;
          end else begin
            w_state_nxt   = ST_ISSUE;
            w_ibuf_go_nxt = (w_sel_wr == DIR_WR);
            w_obuf_go_nxt = (w_sel_wr == DIR_RD);
          end
        end
      end
      ST_ISSUE: begin
        if (w_sel_bsy) begin
          w_ibuf_go_nxt = 1'b0;
          w_obuf_go_nxt = 1'b0;
          w_state_nxt   = ST_RUN;
        end else if (r_tmo == TMO_W'(GO_TIMEOUT - 1)) begin
          w_ibuf_go_nxt = 1'b0;
          w_obuf_go_nxt = 1'b0;
          w_fault_nxt   = r_grant;
          w_state_nxt   = ST_RESP;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      ST_RUN: begin
        if (!w_sel_bsy) begin
          w_state_nxt = ST_RESP;
          if (w_sel_fault) w_fault_nxt = r_grant;
          else             w_done_nxt  = r_grant;
        end
      end
      ST_RESP: begin
        w_grant_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_last      <= IDX_W'(NUM_REQ - 1);
      r_grant     <= '0;
      r_done      <= '0;
      r_fault     <= '0;
      r_ibuf_go   <= 1'b0;
      r_obuf_go   <= 1'b0;
      r_dir       <= DIR_RD;
      r_tmo       <= '0;
      r_ibuf_cnt  <= '0;
      r_obuf_cnt  <= '0;
      r_ibuf_badr <= '0;
      r_obuf_badr <= '0;
      r_ibuf_dadr <= '0;
      r_obuf_dadr <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_grant     <= w_grant_nxt;
      r_done      <= w_done_nxt;
      r_fault     <= w_fault_nxt;
      r_ibuf_go   <= w_ibuf_go_nxt;
      r_obuf_go   <= w_obuf_go_nxt;
      r_dir       <= w_dir_nxt;
      r_tmo       <= w_tmo_nxt;
      r_ibuf_cnt  <= w_ibuf_cnt_nxt;
      r_obuf_cnt  <= w_obuf_cnt_nxt;
      r_ibuf_badr <= w_ibuf_badr_nxt;
      r_obuf_badr <= w_obuf_badr_nxt;
      r_ibuf_dadr <= w_ibuf_dadr_nxt;
      r_obuf_dadr <= w_obuf_dadr_nxt;
    end
  end

  assign o_grant            = r_grant;
  assign o_done             = r_done;
  assign o_fault            = r_fault;
  assign o_ibuf_go          = r_ibuf_go;
  assign o_obuf_go          = r_obuf_go;
  assign o_ibuf_count       = r_ibuf_cnt;
  assign o_obuf_count       = r_obuf_cnt;
  assign o_ibuf_start_addrb = r_ibuf_badr;
  assign o_obuf_start_addra = r_obuf_badr;
  assign o_ibuf_ddr3_addrb  = r_ibuf_dadr;
  assign o_obuf_ddr3_addra  = r_obuf_dadr;
  assign o_busy             = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ui_arbiter.sv
`default_nettype none
// ==================================================================
// tb_ddr3_ui_arbiter : directed self-checking bench for ddr3_ui_arbiter
// Rev 1.0
// ==================================================================
module tb_ddr3_ui_arbiter;

  logic        ui_clk = 1'b0;
  logic        rst_n;
  logic        i_app_phy_init_done;
  logic [1:0]  i_req;
  logic [1:0]  i_req_wr;
  logic [19:0] i_req_count;
  logic [19:0] i_req_buf_addr;
  logic [55:0] i_req_ddr3_addr;
  logic [1:0]  o_grant, o_done, o_fault;
  logic        o_ibuf_go, o_obuf_go;
  logic [9:0]  o_ibuf_count, o_obuf_count, o_ibuf_start_addrb, o_obuf_start_addra;
  logic [27:0] o_ibuf_ddr3_addrb, o_obuf_ddr3_addra;
  logic        i_ibuf_bsy, i_obuf_bsy, i_ibuf_ddr3_fault, i_obuf_ddr3_fault;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  ddr3_ui_arbiter dut (
    .ui_clk              (ui_clk),
    .rst_n               (rst_n),
    .i_app_phy_init_done (i_app_phy_init_done),
    .i_req               (i_req),
    .i_req_wr            (i_req_wr),
    .i_req_count         (i_req_count),
    .i_req_buf_addr      (i_req_buf_addr),
    .i_req_ddr3_addr     (i_req_ddr3_addr),
    .o_grant             (o_grant),
    .o_done              (o_done),
    .o_fault             (o_fault),
    .o_ibuf_go           (o_ibuf_go),
    .o_obuf_go           (o_obuf_go),
    .o_ibuf_count        (o_ibuf_count),
    .o_obuf_count        (o_obuf_count),
    .o_ibuf_start_addrb  (o_ibuf_start_addrb),
    .o_obuf_start_addra  (o_obuf_start_addra),
    .o_ibuf_ddr3_addrb   (o_ibuf_ddr3_addrb),
    .o_obuf_ddr3_addra   (o_obuf_ddr3_addra),
    .i_ibuf_bsy          (i_ibuf_bsy),
    .i_obuf_bsy          (i_obuf_bsy),
    .i_ibuf_ddr3_fault   (i_ibuf_ddr3_fault),
    .i_obuf_ddr3_fault   (i_obuf_ddr3_fault),
    .o_busy              (o_busy)
  );

  always #5 ui_clk = ~ui_clk;

  // Engine responder: raises bsy one edge after go, holds it eng_lat cycles.
  int   eng_lat   = 20;
  logic eng_never = 1'b0;
  logic eng_fault = 1'b0;
  int   eng_cnt;

  always @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      i_ibuf_bsy        <= 1'b0;
      i_obuf_bsy        <= 1'b0;
      i_ibuf_ddr3_fault <= 1'b0;
      i_obuf_ddr3_fault <= 1'b0;
      eng_cnt           <= 0;
    end else if (i_ibuf_bsy || i_obuf_bsy) begin
      if (eng_cnt == 1) begin
        if (i_ibuf_bsy) i_ibuf_ddr3_fault <= eng_fault;
        if (i_obuf_bsy) i_obuf_ddr3_fault <= eng_fault;
        i_ibuf_bsy <= 1'b0;
        i_obuf_bsy <= 1'b0;
      end
      eng_cnt <= eng_cnt - 1;
    end else if (!eng_never && (o_ibuf_go || o_obuf_go)) begin
      i_ibuf_bsy        <= o_ibuf_go;
      i_obuf_bsy        <= o_obuf_go;
      i_ibuf_ddr3_fault <= 1'b0;
      i_obuf_ddr3_fault <= 1'b0;
      eng_cnt           <= eng_lat;
    end
  end

  // Observers sampled on the falling edge.
  int         cyc = 0, go_run = 0, go_width = 0, both_go = 0, obuf_rises = 0;
  int         done_cyc = -1000, min_gap = 1000;
  logic       prev_go = 1'b0, prev_obuf = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  int         grant_log[$];

  always @(negedge ui_clk) begin
    cyc <= cyc + 1;
    if (o_ibuf_go && o_obuf_go) both_go <= both_go + 1;
    if (o_ibuf_go || o_obuf_go) go_run <= go_run + 1;
    else if (go_run != 0) begin
      go_width <= go_run;
      go_run   <= 0;
    end
    if (o_obuf_go && !prev_obuf) obuf_rises <= obuf_rises + 1;
    if ((o_ibuf_go || o_obuf_go) && !prev_go && ((cyc - done_cyc) < min_gap))
      min_gap <= cyc - done_cyc;
    if (o_done != 2'b00) done_cyc <= cyc;
    if (o_grant != prev_grant && o_grant != 2'b00) grant_log.push_back(o_grant[1] ? 1 : 0);
    prev_go    <= o_ibuf_go || o_obuf_go;
    prev_obuf  <= o_obuf_go;
    prev_grant <= o_grant;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ui_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int k, input logic wr, input logic [9:0] cnt,
                         input logic [9:0] badr, input logic [27:0] dadr);
    i_req_wr[k]               = wr;
    i_req_count[k*10 +: 10]   = cnt;
    i_req_buf_addr[k*10 +: 10] = badr;
    i_req_ddr3_addr[k*28 +: 28] = dadr;
  endtask

  task automatic wait_resp(input string tag, input int max, output int n);
    n = 0;
    while ((o_done | o_fault) == 2'b00 && n < max) begin
      tick(1);
      n++;
    end
    chk({tag, "_seen"}, 64'((o_done | o_fault) != 2'b00), 64'd1);
  endtask

  initial begin
    int n, nd, base, rise0;
    logic [7:0] order;

    rst_n = 1'b0;
    i_app_phy_init_done = 1'b0;
    i_req = '0; i_req_wr = '0; i_req_count = '0; i_req_buf_addr = '0; i_req_ddr3_addr = '0;
    tick(2);
    chk("reset_ctrl", {o_grant, o_done, o_fault, o_busy, o_ibuf_go, o_obuf_go,
                       o_ibuf_count, o_obuf_count, o_ibuf_start_addrb, o_obuf_start_addra}, 64'd0);
    chk("reset_addr", {o_ibuf_ddr3_addrb, o_obuf_ddr3_addra}, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // Pending request held off by calibration, then a single write job.
    set_req(0, 1'b1, 10'd8, 10'h010, 28'h100);
    i_req = 2'b01;
    tick(3);
    chk("no_grant_before_init", {o_grant, o_busy, o_ibuf_go}, 64'd0);
    rise0 = obuf_rises;
    i_app_phy_init_done = 1'b1;
    tick(1);
    chk("wr_grant", {o_grant, o_ibuf_go, o_obuf_go}, {2'b01, 1'b1, 1'b0});
    chk("wr_setup", {o_ibuf_count, o_ibuf_start_addrb, o_ibuf_ddr3_addrb}, {10'd8, 10'h010, 28'h100});
    chk("rd_setup_untouched", {o_obuf_count, o_obuf_start_addra}, 64'd0);
    tick(1);
    chk("wr_go_cycle2", o_ibuf_go, 1'b1);
    tick(1);
    chk("wr_go_dropped", {o_ibuf_go, o_busy}, {1'b0, 1'b1});
    wait_resp("wr_done", 60, n);
    chk("wr_done_latency", n, 20);
    chk("wr_done_pulse", {o_done, o_fault, o_grant}, {2'b01, 2'b00, 2'b01});
    i_req = 2'b00;
    tick(1);
    chk("wr_pulse_end", {o_done, o_grant, o_busy}, 64'd0);
    chk("wr_go_width", go_width, 2);
    chk("wr_no_obuf_go", obuf_rises - rise0, 0);

    // Zero-length read on requester 1: immediate done, no go.
    set_req(1, 1'b0, 10'd0, 10'h020, 28'h200);
    i_req = 2'b10;
    tick(1);
    chk("zero_done", {o_grant, o_done, o_ibuf_go, o_obuf_go}, {2'b10, 2'b10, 1'b0, 1'b0});
    i_req = 2'b00;
    tick(1);
    chk("zero_pulse_end", {o_done, o_grant}, 64'd0);

    // Both requesters held continuously for four jobs.
    eng_lat = 3;
    set_req(0, 1'b1, 10'd4, 10'h040, 28'h400);
    set_req(1, 1'b0, 10'd5, 10'h050, 28'h500);
    base = grant_log.size();
    i_req = 2'b11;
    nd = 0;
    n = 0;
    while (nd < 4 && n < 200) begin
      tick(1);
      n++;
      if (o_done != 2'b00) nd++;
    end
    i_req = 2'b00;
    tick(2);
    chk("rr_jobs", nd, 4);
    order = '1;
    if (grant_log.size() >= base + 4)
      order = {grant_log[base][1:0], grant_log[base+1][1:0], grant_log[base+2][1:0], grant_log[base+3][1:0]};
    chk("rr_order", order, 8'b00_01_00_01);
    chk("rr_min_gap", min_gap, 2);

    // Read job ending in an engine fault.
    eng_fault = 1'b1;
    set_req(1, 1'b0, 10'd16, 10'h3FF, 28'hABCDEF0);
    i_req = 2'b10;
    tick(1);
    chk("rd_grant", {o_grant, o_ibuf_go, o_obuf_go}, {2'b10, 1'b0, 1'b1});
    chk("rd_setup", {o_obuf_count, o_obuf_start_addra, o_obuf_ddr3_addra}, {10'd16, 10'h3FF, 28'hABCDEF0});
    chk("wr_setup_held", o_ibuf_count, 10'd4);
    wait_resp("rd_fault", 60, n);
    chk("rd_fault_pulse", {o_fault, o_done}, {2'b10, 2'b00});
    i_req = 2'b00;
    eng_fault = 1'b0;
    tick(1);
    chk("rd_fault_end", {o_fault, o_grant}, 64'd0);

    // Engine never answers go.
    eng_never = 1'b1;
    set_req(0, 1'b1, 10'd1, 10'h001, 28'h1);
    i_req = 2'b01;
    tick(1);
    chk("tmo_go", o_ibuf_go, 1'b1);
    wait_resp("tmo", 60, n);
    chk("tmo_latency", n, 16);
    chk("tmo_fault_pulse", {o_fault, o_done, o_ibuf_go}, {2'b01, 2'b00, 1'b0});
    i_req = 2'b00;
    tick(1);
    chk("tmo_idle", {o_fault, o_grant, o_busy}, 64'd0);
    chk("tmo_go_width", go_width, 16);
    eng_never = 1'b0;

    // Asynchronous reset during RUN, then a fresh job on requester 1.
    eng_lat = 20;
    set_req(0, 1'b1, 10'd3, 10'h033, 28'h333);
    i_req = 2'b01;
    tick(4);
    chk("pre_reset_run", {o_busy, o_ibuf_go, o_grant}, {1'b1, 1'b0, 2'b01});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ctrl", {o_grant, o_done, o_fault, o_busy, o_ibuf_go, o_obuf_go,
                             o_ibuf_count, o_obuf_count, o_ibuf_start_addrb, o_obuf_start_addra}, 64'd0);
    chk("async_reset_addr", {o_ibuf_ddr3_addrb, o_obuf_ddr3_addra}, 64'd0);
    i_req = 2'b00;
    tick(2);
    rst_n = 1'b1;
    set_req(1, 1'b1, 10'd2, 10'h002, 28'h22);
    i_req = 2'b10;
    tick(1);
    chk("post_reset_grant", {o_grant, o_ibuf_go, o_ibuf_count}, {2'b10, 1'b1, 10'd2});
    wait_resp("post_reset", 60, n);
    chk("post_reset_done", {o_done, o_fault}, {2'b10, 2'b00});
    i_req = 2'b00;
    tick(2);
    chk("never_both_go", both_go, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
